// File: rtl/audio_i2s_out.sv
// audio_i2s_out: boxcar-decimates the 3 MHz unsigned mixer stream to 48 kHz signed
// samples and serialises each one as a mono I2S frame (same word on left and right).
module audio_i2s_out #(
    parameter int BCLK_HALF = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_3MHz_en,
    input  logic        clk_48KHz_en,
    input  logic [15:0] in,
    output logic [15:0] sample,
    output logic        sample_valid,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_data
);

    localparam int               DIV_W    = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

    logic [20:0]      r_acc;
    logic [5:0]       r_acc_cnt;
    logic [15:0]      r_sample;
    logic             r_sample_valid;

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_bclk;
    logic [4:0]       r_slot;
    logic             r_lrclk;
    logic             r_data;
    logic [15:0]      r_tx_word;

    logic             w_window_full;
    logic             w_div_wrap;
    logic             w_bclk_fall;
    logic [4:0]       w_next_slot;
    logic [4:0]       w_bit_slot;
    logic [3:0]       w_bit_idx;
    logic [15:0]      w_next_word;

    // acc_cnt saturates at 32, so bit 5 alone marks a complete window.
    assign w_window_full = r_acc_cnt[5];

    assign w_div_wrap  = (r_div_cnt == DIV_LAST);
    assign w_bclk_fall = w_div_wrap && r_bclk;
    assign w_next_slot = r_slot + 5'd1;
    assign w_bit_slot  = w_next_slot - 5'd1;
    assign w_bit_idx   = ~w_bit_slot[3:0];
    // Slot 1 starts a new word, so its MSB comes straight from the sample register.
    assign w_next_word = (w_next_slot == 5'd1) ? r_sample : r_tx_word;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register, including the accumulator, is cleared by the async
        // reset so a reset mid-window never leaks a partial sum into the next one.
        if (!rst_n) begin
            r_acc          <= '0;
            r_acc_cnt      <= '0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            // NOTE: default-low assignment first makes sample_valid a single-clk pulse.
            r_sample_valid <= 1'b0;
            if (clk_48KHz_en) begin
                if (w_window_full) begin
                    r_sample       <= r_acc[20:5] ^ 16'h8000;
                    r_sample_valid <= 1'b1;
                end
                if (clk_3MHz_en) begin
                    r_acc     <= {5'd0, in};
                    r_acc_cnt <= 6'd1;
                end else begin
                    r_acc     <= '0;
                    r_acc_cnt <= '0;
                end
            end else if (clk_3MHz_en && !w_window_full) begin
                r_acc     <= r_acc + {5'd0, in};
                r_acc_cnt <= r_acc_cnt + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
            r_slot    <= '0;
            r_lrclk   <= 1'b0;
            r_data    <= 1'b0;
            r_tx_word <= '0;
        end else begin
            if (w_div_wrap) begin
                r_div_cnt <= '0;
                r_bclk    <= ~r_bclk;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
            if (w_bclk_fall) begin
                r_slot  <= w_next_slot;
                r_lrclk <= w_next_slot[4];
                r_data  <= w_next_word[w_bit_idx];
                if (w_next_slot == 5'd1) begin
                    r_tx_word <= r_sample;
                end
            end
        end
    end

    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;
    assign i2s_bclk     = r_bclk;
    assign i2s_lrclk    = r_lrclk;
    assign i2s_data     = r_data;

endmodule
